pipe_mux_nto1: RTL
==================

PIPE_MUX_NTO1 -- requirements
Module: pipe_mux_nto1

Interface
REQ-001 Parameter N_IN, default 8: number of selectable input channels, legal range 2..64.
REQ-002 Parameter WIDTH, default 32: data bits per channel, legal range 1..64.
REQ-003 Localparam SEL_W = $clog2(N_IN): select width.
REQ-004 i_clk  input  1: single clock; all state changes on its rising edge.
REQ-005 i_reset  input  1: reset, synchronous and active-high.
REQ-006 i_data  input  N_IN x WIDTH (packed): channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 i_sel  input  SEL_W: binary channel select, sampled with i_data.
REQ-008 i_valid  input  1: upstream beat present.
REQ-009 o_ready  output  1: block accepts a beat this cycle.
REQ-010 o_data  output  WIDTH: selected, registered data.
REQ-011 o_sel_err  output  1: the current output beat had i_sel >= N_IN; qualified by o_valid.
REQ-012 o_valid  output  1: downstream beat present.
REQ-013 i_ready  input  1: downstream accepts the beat.

Function
REQ-014 Input transfer occurs when i_valid & o_ready; output transfer occurs when o_valid & i_ready.
REQ-015 Selected data = channel i_sel when i_sel < N_IN, else all-zero with o_sel_err = 1 for that beat.
REQ-016 Latency: an accepted beat appears on o_data/o_valid exactly one cycle after acceptance when the output register was empty or drained in the same cycle.
REQ-017 While o_valid & ~i_ready, o_data and o_sel_err are held stable; no beat is dropped, duplicated or reordered.
REQ-018 Beats carry their own o_sel_err flag; the flag is not sticky across beats.
REQ-019 Simultaneous input and output transfer in a full-to-full case keeps occupancy unchanged at full throughput (one beat per cycle).
REQ-020 i_sel and i_data are ignored when i_valid = 0 or o_ready = 0.

Reset
REQ-021 While i_reset = 1: o_valid = 0, o_data = 0, o_sel_err = 0, control state = EMPTY, all buffered beats discarded.
REQ-022 o_ready = 0 during the reset cycle; o_ready = 1 the first cycle after i_reset deasserts.
REQ-023 Reset asserted mid-stall discards the held beat; no output transfer is reported after reset.

Configuration
REQ-024 Macro PIPE_MUX_SKID_EN defined: two-entry skid buffer, states EMPTY (0 beats), ONE (main register full), TWO (main + skid full); o_ready is registered, = (state != TWO).
REQ-025 Transitions with macro: EMPTY->ONE on input; ONE->TWO on input & ~output; ONE->EMPTY on output & ~input; ONE->ONE on both; TWO->ONE on output (skid moves to main); TWO holds otherwise.
REQ-026 Macro undefined: single output register, states EMPTY/ONE only; o_ready = ~o_valid | i_ready (combinational from i_ready); throughput still one beat per cycle.
REQ-027 Port list, latency and ordering are identical with and without the macro.

Structure
REQ-028 Package pipe_mux_pkg holds the state typedef (EMPTY, ONE, TWO) and parameter-range limit constants.
REQ-029 Selection logic is a combinational sub-module mux_nto1 (parametrised N_IN, WIDTH, outputs data and out-of-range flag); pipe_mux_nto1 adds registers and handshake.

Verification
REQ-030 N_IN=8, WIDTH=32, i_data[k]=32'h1000_0000+k, i_sel=5, i_valid=1, i_ready=1 -> next cycle o_valid=1, o_data=32'h1000_0005, o_sel_err=0.
REQ-031 N_IN=6, i_sel=7 accepted -> o_data=0, o_sel_err=1 for that beat only; following beat with i_sel=2 -> o_sel_err=0.
REQ-032 Stream sel 0,1,2,3 with i_ready=0 for 3 cycles then 1 -> outputs channels 0,1,2,3 in order, none lost; with PIPE_MUX_SKID_EN o_ready falls after 2 beats held.
REQ-033 i_valid=1, i_ready=1 for 20 cycles with incrementing sel -> 20 output beats in 20 consecutive cycles after the first-beat latency.
REQ-034 i_reset=1 while o_valid=1, i_ready=0 -> next cycle o_valid=0, o_data=0; first cycle after release o_ready=1.
REQ-035 Run REQ-030..034 both with PIPE_MUX_SKID_EN defined and undefined; identical data streams required.

Source files
------------

// File: rtl/pipe_mux_pkg.sv
// Shared types and parameter limits for the pipelined N-to-1 channel mux.
package pipe_mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int N_IN_MIN  = 2;
    localparam int N_IN_MAX  = 64;
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/pipe_mux_nto1_mux.sv
// Combinational N-to-1 channel select; an out-of-range select yields zero data and a flag.
module mux_nto1
    import pipe_mux_pkg::*;
#(
    parameter int  N_IN  = 8,
    parameter int  WIDTH = 32,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]      i_sel,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_sel_err
);

    if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
        $error("mux_nto1: N_IN out of legal range");
    end
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("mux_nto1: WIDTH out of legal range");
    end

    // Flag stays set unless some channel index matches the select.
    always_comb begin
        o_data    = '0;
        o_sel_err = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data    = i_data[k*WIDTH +: WIDTH];
                o_sel_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_mux_nto1.sv
// Registered N-to-1 channel mux with valid/ready handshake on both sides.
// Optional two-entry skid buffer with registered o_ready: define PIPE_MUX_SKID_EN.
//
// state | meaning
// EMPTY | no beat held, o_valid low
// ONE   | main output register holds a beat
// TWO   | main and skid registers both hold beats (skid build only), o_ready low
module pipe_mux_nto1
    import pipe_mux_pkg::*;
#(
    parameter int  N_IN  = 8,
    parameter int  WIDTH = 32,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [N_IN*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]      i_sel,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_sel_err,
    output logic                  o_valid,
    input  logic                  i_ready
);

    logic [WIDTH-1:0] mux_data;
    logic             mux_err;

    mux_nto1 #(
        .N_IN  (N_IN),
        .WIDTH (WIDTH)
    ) u_mux (
        .i_data    (i_data),
        .i_sel     (i_sel),
        .o_data    (mux_data),
        .o_sel_err (mux_err)
    );

    pipe_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic             in_xfer;
    logic             out_xfer;

    assign o_valid   = (state_q != EMPTY);
    assign o_data    = data_q;
    assign o_sel_err = err_q;
    assign in_xfer   = i_valid & o_ready;
    assign out_xfer  = o_valid & i_ready;

`ifdef PIPE_MUX_SKID_EN

    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q, skid_err_d;
    logic             ready_q, ready_d;

    // ready_q comes out of reset high so the first cycle after release accepts.
    assign o_ready = ready_q & ~i_reset;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        err_d       = err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    data_d  = mux_data;
                    err_d   = mux_err;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    data_d = mux_data;
                    err_d  = mux_err;
                end else if (in_xfer) begin
                    skid_data_d = mux_data;
                    skid_err_d  = mux_err;
                    state_d     = TWO;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    data_d  = skid_data_q;
                    err_d   = skid_err_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        ready_d = (state_d != TWO);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= EMPTY;
            data_q      <= '0;
            err_q       <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            err_q       <= err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            ready_q     <= ready_d;
        end
    end

`else

    // Accept whenever the output register is empty or draining this cycle.
    assign o_ready = ~i_reset & (~o_valid | i_ready);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
        if (in_xfer) begin
            data_d  = mux_data;
            err_d   = mux_err;
            state_d = ONE;
        end else if (out_xfer) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`endif

endmodule
